// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one step per cycle.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed product instead.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;

  // Request decode
  logic              is_div_in, a_signed_in, b_signed_in;
  logic              sa, sb, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  assign is_div_in   = funct3[2];
  assign a_signed_in = is_div_in ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
  assign b_signed_in = is_div_in ? ~funct3[0] : (funct3 == 3'b001);
  assign sa          = a_signed_in & rs1[XLEN-1];
  assign sb          = b_signed_in & rs2[XLEN-1];
  assign mag_a       = sa ? (~rs1 + 32'd1) : rs1;
  assign mag_b       = sb ? (~rs2 + 32'd1) : rs2;
  // Remainder follows the dividend's sign; product and quotient use the XOR.
  assign neg_in      = (is_div_in && funct3[1]) ? sa : (sa ^ sb);

  assign div_by_zero = is_div_in && (rs2 == 32'd0);
  assign div_ovf     = is_div_in && !funct3[0] &&
                       (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

`ifdef MDU_FAST_MUL_EN
  logic signed [63:0] fast_a, fast_b;
  logic        [63:0] fast_prod;
  logic        [XLEN-1:0] fast_res;

  // Sign-extending from the 33-bit signed view gives the exact product mod 2^64.
  assign fast_a    = {{32{sa}}, rs1};
  assign fast_b    = {{32{sb}}, rs2};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
  assign special   = div_by_zero || div_ovf || !is_div_in;

  always_comb begin
    special_res = 32'd0;
    if (!is_div_in)
      special_res = fast_res;
    else if (div_by_zero)
      special_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end
`else
  assign special = div_by_zero || div_ovf;

  always_comb begin
    special_res = 32'd0;
    if (div_by_zero)
      special_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end
`endif

  // One radix-2 step of each algorithm on the shared {hi, lo} register pair
  logic [32:0]       sum33, rem_sh, diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [63:0]       prod, prod_fix;
  logic [XLEN-1:0]   div_word, div_fix, final_res;

  assign sum33  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : 32'd0)};
  assign rem_sh = {hi_q, lo_q[31]};
  assign diff   = rem_sh - {1'b0, opb_q};

  always_comb begin
    if (op_q[2]) begin
      step_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
      step_lo = {lo_q[30:0], ~diff[32]};
    end else begin
      step_hi = sum33[32:1];
      step_lo = {sum33[0], lo_q[31:1]};
    end
  end

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  assign div_word = op_q[1] ? step_hi : step_lo;
  assign div_fix  = neg_q ? (~div_word + 32'd1) : div_word;

  always_comb begin
    if (op_q[2])
      final_res = div_fix;
    else if (op_q[1:0] == 2'b00)
      final_res = prod_fix[31:0];
    else
      final_res = prod_fix[63:32];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d  = funct3;
          neg_d = neg_in;
          cnt_d = 5'd0;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            hi_d    = 32'd0;
            lo_d    = is_div_in ? mag_a : mag_b;
            opb_d   = is_div_in ? mag_b : mag_a;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush discards the operation without touching the visible result
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
